// File: rtl/cp0_exception_unit.sv
// CP0 register file and exception/interrupt arbiter in the M stage of the P7 pipeline.
// Optional Count register (addr 9) is enabled by defining CP0_COUNT_EN.
module cp0_exception_unit #(
    parameter logic [31:0] PRID         = 32'h4D495053,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        overflow_in,
    input  logic [4:0]  exc_code_in,
    input  logic [31:0] pc_in,
    input  logic        bd_in,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_din,
    input  logic        eret_in,
    output logic [31:0] cp0_dout,
    output logic [31:0] epc_out,
    output logic        req,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] ADDR_COUNT = 5'd9;
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;
    localparam logic [4:0] EXC_OV     = 5'd12;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic [4:0]  exc_sel;
    logic        int_req;
    logic        exc_req;
    logic [31:0] epc_next;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        exc_sel = exc_code_in;
        if (exc_code_in == 5'd0)
            exc_sel = overflow_in ? EXC_OV : 5'd0;
    end

    assign int_req    = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req    = (exc_sel != 5'd0) & ~sr_exl;
    assign req        = int_req | exc_req;
    assign epc_next   = (bd_in ? pc_in - 32'd4 : pc_in) & 32'hFFFF_FFFC;
    assign epc_out    = epc;
    assign handler_pc = HANDLER_ADDR;

    // NOTE: state uses non-blocking assignments; the eret clear below relies on last-NBA-wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= hw_int;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_req ? 5'd0 : exc_sel;
                cause_bd  <= bd_in;
                epc       <= epc_next;
            end else begin
                if (cp0_we && cp0_addr == ADDR_SR) begin
                    sr_im  <= cp0_din[15:10];
                    sr_exl <= cp0_din[1];
                    sr_ie  <= cp0_din[0];
                end
                if (cp0_we && cp0_addr == ADDR_EPC)
                    epc <= cp0_din & 32'hFFFF_FFFC;
                // Same-cycle mtc0 SR is applied first, then eret clears EXL.
                if (eret_in)
                    sr_exl <= 1'b0;
            end
        end
    end

`ifdef CP0_COUNT_EN
    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= 32'd0;
        else if (cp0_we && !req && cp0_addr == ADDR_COUNT)
            count <= cp0_din;
        else
            count <= count + 32'd1;
    end
`endif

    always_comb begin
        cp0_dout = 32'd0;
        case (cp0_addr)
`ifdef CP0_COUNT_EN
            ADDR_COUNT: cp0_dout = count;
`endif
            ADDR_SR:    cp0_dout = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            ADDR_CAUSE: cp0_dout = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
            ADDR_EPC:   cp0_dout = epc;
            ADDR_PRID:  cp0_dout = PRID;
            default:    cp0_dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed testbench for cp0_exception_unit; Count checks follow CP0_COUNT_EN.
module tb_cp0_exception_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        overflow_in;
    logic [4:0]  exc_code_in;
    logic [31:0] pc_in;
    logic        bd_in;
    logic [5:0]  hw_int;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_din;
    logic        eret_in;
    logic [31:0] cp0_dout;
    logic [31:0] epc_out;
    logic        req;
    logic [31:0] handler_pc;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    cp0_exception_unit dut (
        .clk         (clk),
        .reset       (reset),
        .overflow_in (overflow_in),
        .exc_code_in (exc_code_in),
        .pc_in       (pc_in),
        .bd_in       (bd_in),
        .hw_int      (hw_int),
        .cp0_we      (cp0_we),
        .cp0_addr    (cp0_addr),
        .cp0_din     (cp0_din),
        .eret_in     (eret_in),
        .cp0_dout    (cp0_dout),
        .epc_out     (epc_out),
        .req         (req),
        .handler_pc  (handler_pc)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        overflow_in = 1'b0;
        exc_code_in = 5'd0;
        bd_in       = 1'b0;
        hw_int      = 6'd0;
        cp0_we      = 1'b0;
        cp0_din     = 32'd0;
        eret_in     = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] expected);
        cp0_addr = addr;
        #1;
        check(tag, cp0_dout, expected);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_we   = 1'b1;
        cp0_addr = addr;
        cp0_din  = data;
        tick();
        cp0_we   = 1'b0;
    endtask

    task automatic eret();
        eret_in = 1'b1;
        tick();
        eret_in = 1'b0;
    endtask

    initial begin
        idle();
        pc_in    = 32'd0;
        cp0_addr = 5'd0;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        rd("rst_other", 5'd3, 32'h0);
        check("rst_epc_out", epc_out, 32'h0);
        check("rst_req", {31'd0, req}, 32'd0);
        check("handler_pc", handler_pc, 32'h0000_4180);

        // Overflow in M
        overflow_in = 1'b1;
        pc_in = 32'h3010;
        #1;
        check("ov_req", {31'd0, req}, 32'd1);
        tick();
        check("ov_epc", epc_out, 32'h3010);
        rd("ov_cause", 5'd13, 32'h0000_0030);
        rd("ov_sr", 5'd12, 32'h0000_0002);
        check("nest_req", {31'd0, req}, 32'd0);
        overflow_in = 1'b0;
        eret();
        rd("eret_sr", 5'd12, 32'h0);
        check("eret_epc", epc_out, 32'h3010);

        // Older-stage code in a delay slot beats overflow
        exc_code_in = 5'd4;
        overflow_in = 1'b1;
        bd_in = 1'b1;
        pc_in = 32'h3024;
        #1;
        check("bd_req", {31'd0, req}, 32'd1);
        tick();
        idle();
        rd("bd_cause", 5'd13, 32'h8000_0010);
        check("bd_epc", epc_out, 32'h3020);
        eret();

        // eret together with exception: exception wins
        overflow_in = 1'b1;
        eret_in = 1'b1;
        pc_in = 32'h3100;
        tick();
        idle();
        rd("eret_exc_sr", 5'd12, 32'h0000_0002);
        check("eret_exc_epc", epc_out, 32'h3100);
        eret();

        // mtc0 EPC suppressed by simultaneous req
        overflow_in = 1'b1;
        pc_in = 32'h3200;
        cp0_we = 1'b1;
        cp0_addr = 5'd14;
        cp0_din = 32'h0000_5003;
        tick();
        idle();
        check("sup_epc", epc_out, 32'h3200);
        eret();

        // Readback and read-only registers
        mtc0(5'd14, 32'h0000_5003);
        rd("wr_epc", 5'd14, 32'h0000_5000);
        rd("prid", 5'd15, 32'h4D49_5053);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0000_0030);

        // Interrupt beats overflow
        mtc0(5'd12, 32'h0000_0401);
        rd("sr_wr", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        overflow_in = 1'b1;
        pc_in = 32'h3300;
        #1;
        check("int_req", {31'd0, req}, 32'd1);
        tick();
        idle();
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr", 5'd12, 32'h0000_0403);
        check("int_epc", epc_out, 32'h3300);
        eret();
        rd("int_eret_sr", 5'd12, 32'h0000_0401);

        // mtc0 SR together with eret: write applied, EXL cleared
        cp0_we = 1'b1;
        cp0_addr = 5'd12;
        cp0_din = 32'h0000_0403;
        eret_in = 1'b1;
        tick();
        idle();
        rd("sr_eret", 5'd12, 32'h0000_0401);

        // IE = 0 masks the interrupt; IP still tracks hw_int
        mtc0(5'd12, 32'h0000_0400);
        hw_int = 6'b000001;
        #1;
        check("ie0_req", {31'd0, req}, 32'd0);
        tick();
        rd("ip_track", 5'd13, 32'h0000_0400);
        hw_int = 6'd0;

        // pc_in - 4 wraps
        exc_code_in = 5'd8;
        bd_in = 1'b1;
        pc_in = 32'h0000_0000;
        tick();
        idle();
        check("wrap_epc", epc_out, 32'hFFFF_FFFC);
        rd("wrap_cause", 5'd13, 32'h8000_0020);

        // Reset mid-exception
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd("rst2_sr", 5'd12, 32'h0);
        check("rst2_epc", epc_out, 32'h0);
        check("rst2_req", {31'd0, req}, 32'd0);
        overflow_in = 1'b1;
        #1;
        check("rst2_exc_req", {31'd0, req}, 32'd1);
        idle();

`ifdef CP0_COUNT_EN
        mtc0(5'd9, 32'hFFFF_FFFE);
        rd("count0", 5'd9, 32'hFFFF_FFFE);
        tick();
        rd("count1", 5'd9, 32'hFFFF_FFFF);
        tick();
        rd("count2", 5'd9, 32'h0000_0000);
        tick();
        rd("count3", 5'd9, 32'h0000_0001);
`else
        mtc0(5'd9, 32'h1234_5678);
        rd("count_off", 5'd9, 32'h0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
